// File: rtl/alu_sweep_gen_if.sv
// Vector bus between the sweep generator and the 4-bit ALU.
// master = generator (drives vector + valid), slave = consumer (drives ready).
interface alu_sweep_gen_if;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] operation_o;
  logic [3:0] operand1_o;
  logic [3:0] operand2_o;

  modport master (output valid_o, output operation_o, output operand1_o,
                  output operand2_o, input ready_i);
  modport slave  (input valid_o, input operation_o, input operand1_o,
                  input operand2_o, output ready_i);
endinterface

// File: rtl/alu_sweep_gen.sv
// Operand/operation sweep generator feeding the 4-bit ALU.
// Walks op ADD,SUB,OR,AND; per op a nested operand1/operand2 sweep; one
// vector per valid/ready handshake.
// Optional result checker enabled by macro ALU_SWEEP_CHECK_EN.
module alu_sweep_gen #(
  parameter int OP1_INIT = 4,
  parameter int OP1_INC  = 3,
  parameter int OP2_INIT = 7,
  parameter int OP2_INC  = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  alu_sweep_gen_if.master vec,
  output logic            busy_o,
  output logic            done_o,
  output logic [10:0]     count_o
`ifdef ALU_SWEEP_CHECK_EN
  ,
  input  logic [3:0]      result_i,
  output logic [10:0]     err_cnt_o,
  output logic            err_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic [10:0] cnt_q, cnt_d;
  logic        hs, start_acc, last_vec;
  // 5-bit sums so an overflow past 15 is visible
  logic [4:0]  i_next, j_next;

  assign hs        = (state_q == ISSUE) && vec.ready_i;
  assign start_acc = (state_q == IDLE) && start_i;
  assign j_next    = {1'b0, b_q} + 5'(OP2_INC);
  assign i_next    = {1'b0, a_q} + 5'(OP1_INC);
  assign last_vec  = (j_next >= 5'd16) && (i_next >= 5'd16) && (op_q == 2'd3);

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   if (hs && last_vec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // status/handshake outputs decoded from state
  always_comb begin
    vec.valid_o = (state_q == ISSUE);
    busy_o      = (state_q == ISSUE);
    done_o      = (state_q == DONE);
  end

  // vector and count update: load on start, advance nested sweep on handshake
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (start_acc) begin
      op_d  = 2'd0;
      a_d   = 4'(OP1_INIT);
      b_d   = 4'(OP2_INIT);
      cnt_d = '0;
    end else if (hs) begin
      cnt_d = cnt_q + 11'd1;
      if (j_next < 5'd16) begin
        b_d = j_next[3:0];
      end else begin
        b_d = 4'(OP2_INIT);
        if (i_next < 5'd16) begin
          a_d = i_next[3:0];
        end else begin
          a_d  = 4'(OP1_INIT);
          op_d = op_q + 2'd1;
        end
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec.operation_o = op_q;
  assign vec.operand1_o  = a_q;
  assign vec.operand2_o  = b_q;
  assign count_o         = cnt_q;

`ifdef ALU_SWEEP_CHECK_EN
  logic [3:0]  ref_res;
  logic [10:0] err_cnt_q, err_cnt_d;
  logic        err_q, err_d;

  // reference ALU result for the vector currently presented
  always_comb begin
    ref_res = '0;
    case (op_q)
      2'd0: ref_res = a_q + b_q;
      2'd1: ref_res = a_q - b_q;
      2'd2: ref_res = a_q | b_q;
      2'd3: ref_res = a_q & b_q;
      default: ref_res = '0;
    endcase
  end

  // error tally: cleared on accepted start, bumped on mismatching handshake
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_d     = err_q;
    if (start_acc) begin
      err_cnt_d = '0;
      err_d     = 1'b0;
    end else if (hs && (result_i != ref_res)) begin
      err_cnt_d = err_cnt_q + 11'd1;
      err_d     = 1'b1;
    end
  end

  // checker registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_alu_sweep_gen.sv
// Scoreboard bench for alu_sweep_gen (default parameters).
module tb_alu_sweep_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [10:0] count;

  always #5 clk = ~clk;

  alu_sweep_gen_if vif ();

`ifdef ALU_SWEEP_CHECK_EN
  logic [3:0]  result;
  logic [10:0] err_cnt;
  logic        err;
  logic        bad_alu = 1'b0;
`endif

  alu_sweep_gen dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .vec     (vif),
    .busy_o  (busy),
    .done_o  (done),
    .count_o (count)
`ifdef ALU_SWEEP_CHECK_EN
    ,
    .result_i  (result),
    .err_cnt_o (err_cnt),
    .err_o     (err)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0: return (a + b) & 15;
      1: return (a - b) & 15;
      2: return a | b;
      default: return a & b;
    endcase
  endfunction

`ifdef ALU_SWEEP_CHECK_EN
  always_comb result = bad_alu ? 4'd0 :
    4'(alu_ref(int'(vif.operation_o), int'(vif.operand1_o), int'(vif.operand2_o)));
`endif

  typedef struct { int op; int a; int b; } vec_t;
  vec_t q[$];

  // expected sequence straight from the nested-loop description
  task automatic load_expected();
    vec_t v;
    q.delete();
    for (int op = 0; op < 4; op++)
      for (int a = 4; a < 16; a += 3)
        for (int b = 7; b < 16; b += 2) begin
          v.op = op; v.a = a; v.b = b;
          q.push_back(v);
        end
  endtask

  function automatic int pack_vec();
    return int'(vif.operation_o) * 256 + int'(vif.operand1_o) * 16 + int'(vif.operand2_o);
  endfunction

  // mode 0: ready always 1; mode 1: ready toggles. abort_at>0: async reset
  // after that many handshakes. pulse_at>=0: extra start pulse mid-sweep.
  task automatic run_sweep(input int mode, input int abort_at, input int pulse_at);
    int   hs_n, last_hs, cyc, exp_err;
    bit   done_seen, pulsed, hs;
    vec_t e;
    load_expected();
    hs_n = 0; last_hs = -10; cyc = 0; done_seen = 0; pulsed = 0; exp_err = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("first_valid", int'(vif.valid_o), 1);
    chk("start_count", int'(count), 0);
    chk("first_vec", pack_vec(), 16'h047);
    while (!done_seen && cyc < 3000) begin
      vif.ready_i = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (pulse_at >= 0 && hs_n == pulse_at && !pulsed) begin
        start = 1'b1; pulsed = 1;
      end else start = 1'b0;
      #1;
      hs = vif.valid_o && vif.ready_i;
      if (done) begin
        done_seen = 1;
        chk("done_after_last_hs", cyc, last_hs + 1);
        chk("done_hs_total", hs_n, 80);
        chk("done_valid_low", int'(vif.valid_o), 0);
        chk("done_busy_low", int'(busy), 0);
        chk("done_count", int'(count), 80);
      end else begin
        chk("busy_eq_valid", int'(busy), int'(vif.valid_o));
        if (hs) begin
          if (q.size() == 0) chk("extra_vector", 1, 0);
          else begin
            e = q.pop_front();
            chk("vec_op", int'(vif.operation_o), e.op);
            chk("vec_op1", int'(vif.operand1_o), e.a);
            chk("vec_op2", int'(vif.operand2_o), e.b);
            if (alu_ref(e.op, e.a, e.b) != 0) exp_err++;
          end
          chk("count_before_hs", int'(count), hs_n);
          case (hs_n)
            1:  chk("vec2", pack_vec(), 16'h049);
            5:  chk("vec6", pack_vec(), 16'h077);
            19: chk("vec20", pack_vec(), 16'h0df);
            20: chk("vec21", pack_vec(), 16'h147);
            79: chk("vec80", pack_vec(), 16'h3df);
            default: ;
          endcase
          hs_n++;
          last_hs = cyc;
          if (abort_at > 0 && hs_n == abort_at) break;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (abort_at > 0) begin
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", int'(vif.valid_o), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_count", int'(count), 0);
      chk("abort_vec", pack_vec(), 0);
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      chk("sweep_finished", int'(done_seen), 1);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("count_hold", int'(count), 80);
`ifdef ALU_SWEEP_CHECK_EN
      chk("err_cnt", int'(err_cnt), bad_alu ? exp_err : 0);
      chk("err_flag", int'(err), (bad_alu && exp_err > 0) ? 1 : 0);
`endif
    end
    vif.ready_i = 1'b0;
  endtask

  initial begin
    vif.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(vif.valid_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_vec", pack_vec(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", int'(vif.valid_o), 0);
    run_sweep(0, 0, -1);   // back-to-back
    run_sweep(1, 0, -1);   // ready toggling
    run_sweep(0, 30, -1);  // async reset mid-sweep
    run_sweep(0, 0, 10);   // stray start during ISSUE
`ifdef ALU_SWEEP_CHECK_EN
    bad_alu = 1'b1;
    run_sweep(0, 0, -1);
    bad_alu = 1'b0;
    run_sweep(0, 0, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
